// File: rtl/alu_seq.sv
// Sequential Nibbler ALU: registered result and active-low flags, start/busy/done handshake,
// serial shift-left. Define ALU_MUL_EN to enable the serial shift-add multiplier on opcode 111.
module alu_seq #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   S,
  input  logic         notCarryIn,
  input  logic [N-1:0] A_Result,
  input  logic [N-1:0] operand,
  input  logic         notOeALU,
  output logic         busy,
  output logic         done,
  output logic         notC,
  output logic         notZ,
  output logic [N-1:0] ALU_Result
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1
`ifdef ALU_MUL_EN
    , StMul = 2'd2
`endif
  } state_e;

  state_e stateQ, stateD;

  logic [N-1:0]    resultQ, resultD;
  logic            notCQ, notCD, notZQ, notZD, doneQ, doneD;
  logic [N-1:0]    accQ, accD;
  logic [CntW-1:0] cntQ, cntD;
  logic [CntW-1:0] shAmt;
  logic [N:0]      addSum, subSum, cmpSum;
  logic [N-1:0]    norRes, accShift;
  logic            cin;

`ifdef ALU_MUL_EN
  logic [2*N-1:0] mcandQ, mcandD, prodQ, prodD, prodStep;
  logic [N-1:0]   mplierQ, mplierD;
`endif

  assign cin      = ~notCarryIn;
  assign addSum   = {1'b0, A_Result} + {1'b0, operand} + {{N{1'b0}}, cin};
  assign subSum   = {1'b0, A_Result} + {1'b0, ~operand} + {{N{1'b0}}, cin};
  assign cmpSum   = {1'b0, A_Result} + {1'b0, ~operand} + {{N{1'b0}}, 1'b1};
  assign norRes   = ~(A_Result | operand);
  assign accShift = {accQ[N-2:0], 1'b0};

  // Shift amounts beyond the width saturate at N (result all zeros).
  always_comb begin
    if (32'(operand) > 32'(N)) shAmt = CntW'(N);
    else                       shAmt = CntW'(operand);
  end

`ifdef ALU_MUL_EN
  assign prodStep = prodQ + (mplierQ[0] ? mcandQ : '0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateQ <= StIdle;
    else       stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (start && S == 3'b110 && shAmt != '0) stateD = StShift;
`ifdef ALU_MUL_EN
        if (start && S == 3'b111) stateD = StMul;
`endif
      end
      StShift: if (cntQ == CntW'(1)) stateD = StIdle;
`ifdef ALU_MUL_EN
      StMul:   if (cntQ == CntW'(1)) stateD = StIdle;
`endif
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    busy       = (stateQ != StIdle);
    done       = doneQ;
    notC       = notCQ;
    notZ       = notZQ;
    ALU_Result = notOeALU ? {N{1'bz}} : resultQ;
  end

  always_comb begin
    resultD = resultQ;
    notCD   = notCQ;
    notZD   = notZQ;
    doneD   = 1'b0;
    accD    = accQ;
    cntD    = cntQ;
`ifdef ALU_MUL_EN
    mcandD  = mcandQ;
    mplierD = mplierQ;
    prodD   = prodQ;
`endif
    unique case (stateQ)
      StIdle: begin
        if (start) begin
          doneD = 1'b1;
          case (S)
            3'b001: begin
              resultD = A_Result;
              notCD   = ~cmpSum[N];
              notZD   = |cmpSum[N-1:0];
            end
            3'b010: resultD = operand;
            3'b011: begin
              resultD = addSum[N-1:0];
              notCD   = ~addSum[N];
              notZD   = |addSum[N-1:0];
            end
            3'b100: begin
              resultD = norRes;
              notZD   = |norRes;
            end
            3'b101: begin
              resultD = subSum[N-1:0];
              notCD   = ~subSum[N];
              notZD   = |subSum[N-1:0];
            end
            3'b110: begin
              if (shAmt == '0) begin
                resultD = A_Result;
                notZD   = |A_Result;
              end else begin
                doneD = 1'b0;
                accD  = A_Result;
                cntD  = shAmt;
              end
            end
`ifdef ALU_MUL_EN
            3'b111: begin
              doneD   = 1'b0;
              mcandD  = {{N{1'b0}}, A_Result};
              mplierD = operand;
              prodD   = '0;
              cntD    = CntW'(N);
            end
`endif
            default: resultD = A_Result;
          endcase
        end
      end
      StShift: begin
        accD = accShift;
        cntD = cntQ - CntW'(1);
        if (cntQ == CntW'(1)) begin
          resultD = accShift;
          notCD   = ~accQ[N-1];
          notZD   = |accShift;
          doneD   = 1'b1;
        end
      end
`ifdef ALU_MUL_EN
      StMul: begin
        prodD   = prodStep;
        mcandD  = {mcandQ[2*N-2:0], 1'b0};
        mplierD = {1'b0, mplierQ[N-1:1]};
        cntD    = cntQ - CntW'(1);
        if (cntQ == CntW'(1)) begin
          resultD = prodStep[N-1:0];
          notCD   = ~|prodStep[2*N-1:N];
          notZD   = |prodStep[N-1:0];
          doneD   = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resultQ <= '0;
      notCQ   <= 1'b1;
      notZQ   <= 1'b1;
      doneQ   <= 1'b0;
      accQ    <= '0;
      cntQ    <= '0;
    end else begin
      resultQ <= resultD;
      notCQ   <= notCD;
      notZQ   <= notZD;
      doneQ   <= doneD;
      accQ    <= accD;
      cntQ    <= cntD;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcandQ  <= '0;
      mplierQ <= '0;
      prodQ   <= '0;
    end else begin
      mcandQ  <= mcandD;
      mplierQ <= mplierD;
      prodQ   <= prodD;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus random operations checked against
// an arithmetic reference model of results, flags and completion latency.
module tb_alu_seq;

  localparam int unsigned N    = 4;
  localparam int unsigned Mask = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         reset, start, notCarryIn, notOeALU;
  logic [2:0]   S;
  logic [N-1:0] A_Result, operand;
  logic         busy, done, notC, notZ;
  wire  [N-1:0] ALU_Result;

  int numCompared   = 0;
  int numMismatched = 0;

  int unsigned mRes;
  bit          mNotC, mNotZ;

  alu_seq #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .S          (S),
    .notCarryIn (notCarryIn),
    .A_Result   (A_Result),
    .operand    (operand),
    .notOeALU   (notOeALU),
    .busy       (busy),
    .done       (done),
    .notC       (notC),
    .notZ       (notZ),
    .ALU_Result (ALU_Result)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numCompared++;
    if (obs !== exp) begin
      numMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: updates the architectural model and returns cycles from start to done.
  task automatic modelOp(input logic [2:0] s, input int unsigned a, input int unsigned b,
                         input bit nci, output int lat);
    int unsigned cinV, t, k;
    cinV = nci ? 0 : 1;
    lat  = 1;
    case (s)
      3'd1: begin
        t = a + ((~b) & Mask) + 1;
        mRes = a; mNotC = ((t >> N) & 1) == 0; mNotZ = (t & Mask) != 0;
      end
      3'd2: mRes = b;
      3'd3: begin
        t = a + b + cinV;
        mRes = t & Mask; mNotC = ((t >> N) & 1) == 0; mNotZ = mRes != 0;
      end
      3'd4: begin
        mRes = (~(a | b)) & Mask; mNotZ = mRes != 0;
      end
      3'd5: begin
        t = a + ((~b) & Mask) + cinV;
        mRes = t & Mask; mNotC = ((t >> N) & 1) == 0; mNotZ = mRes != 0;
      end
      3'd6: begin
        k = (b > N) ? N : b;
        t = a << k;
        mRes = t & Mask; mNotZ = mRes != 0;
        if (k != 0) mNotC = ((t >> N) & 1) == 0;
        lat = k + 1;
      end
`ifdef ALU_MUL_EN
      3'd7: begin
        t = a * b;
        mRes = t & Mask; mNotC = (t >> N) == 0; mNotZ = mRes != 0;
        lat = N + 1;
      end
`endif
      default: mRes = a;
    endcase
  endtask

  task automatic checkState(input string tag);
    checkEq({tag, ".res"}, ALU_Result, mRes);
    checkEq({tag, ".notC"}, notC, mNotC);
    checkEq({tag, ".notZ"}, notZ, mNotZ);
  endtask

  task automatic runOp(input logic [2:0] s, input int unsigned a, input int unsigned b,
                       input bit nci, input bit pokeBusy, input string tag);
    int lat, got;
    got = 0;
    modelOp(s, a, b, nci, lat);
    @(negedge clk);
    S = s; A_Result = a[N-1:0]; operand = b[N-1:0]; notCarryIn = nci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin
        got = cyc;
        break;
      end
      checkEq({tag, ".busy"}, busy, 1);
      if (pokeBusy && cyc == 1) begin
        S = 3'b010; operand = N'($urandom); start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    checkEq({tag, ".lat"}, got, lat);
    if (got != 0) begin
      checkEq({tag, ".busyAtDone"}, busy, 0);
      checkState(tag);
      @(negedge clk);
      checkEq({tag, ".donePulse"}, done, 0);
      checkEq({tag, ".held"}, ALU_Result, mRes);
    end
  endtask

  task automatic modelReset();
    mRes = 0; mNotC = 1'b1; mNotZ = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; S = '0; A_Result = '0; operand = '0;
    notCarryIn = 1'b1; notOeALU = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkEq("rst.busy", busy, 0);
    checkEq("rst.done", done, 0);
    checkState("rst");
    reset = 1'b0;

    runOp(3'd3, 9, 8, 1'b1, 1'b0, "add9p8");
    runOp(3'd3, 7, 9, 1'b1, 1'b0, "add7p9");
    @(negedge clk);
    notOeALU = 1'b1;
    #1;
    checkEq("oe.notC", notC, mNotC);
    checkEq("oe.notZ", notZ, mNotZ);
    @(negedge clk);
    notOeALU = 1'b0;
    #1;
    checkEq("oe.res", ALU_Result, mRes);

    runOp(3'd1, 5, 5, 1'b1, 1'b0, "cmp55");
    runOp(3'd4, 15, 0, 1'b1, 1'b0, "nor");
    runOp(3'd6, 11, 2, 1'b1, 1'b1, "shl2");
    runOp(3'd6, 11, 0, 1'b1, 1'b0, "shl0");
    runOp(3'd6, 11, 9, 1'b1, 1'b0, "shl9");
    runOp(3'd5, 3, 5, 1'b0, 1'b0, "sub35");
    runOp(3'd5, 9, 4, 1'b1, 1'b0, "sub94b");

    // Abort a shift in flight with an asynchronous reset.
    @(negedge clk);
    S = 3'd6; A_Result = 4'hB; operand = 4'd4; notCarryIn = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    modelReset();
    #1;
    checkEq("abort.busy", busy, 0);
    checkEq("abort.done", done, 0);
    checkState("abort");
    @(negedge clk);
    reset = 1'b0;
    runOp(3'd3, 2, 3, 1'b0, 1'b0, "addAfterAbort");

    runOp(3'd7, 6, 3, 1'b1, 1'b0, "op111");

    for (int i = 0; i < 150; i++) begin
      runOp(3'($urandom), $urandom & Mask, $urandom & Mask, 1'($urandom), 1'($urandom_range(0, 3) == 0),
            "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
